// File: rtl/tty_ram_arbiter_if.sv
// Client and RAM-slave signal bundle for tty_ram_arbiter. The arbiter uses the slave
// modport. The clients and the RAM sit on the master side.
interface tty_ram_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_address;
  logic [NUM_CH*DATA_W-1:0] ch_writedata;
  logic [NUM_CH-1:0]        ch_gnt;
  logic [NUM_CH-1:0]        ch_rvalid;
  logic [DATA_W-1:0]        ch_readdata;
  logic [ADDR_W-1:0]        ram_address;
  logic                     ram_chipselect;
  logic                     ram_clken;
  logic                     ram_write;
  logic [DATA_W-1:0]        ram_writedata;
  logic [DATA_W-1:0]        ram_readdata;

  modport slave (
    input  ch_req, ch_write, ch_address, ch_writedata, ram_readdata,
    output ch_gnt, ch_rvalid, ch_readdata,
    output ram_address, ram_chipselect, ram_clken, ram_write, ram_writedata
  );

  modport master (
    output ch_req, ch_write, ch_address, ch_writedata, ram_readdata,
    input  ch_gnt, ch_rvalid, ch_readdata,
    input  ram_address, ram_chipselect, ram_clken, ram_write, ram_writedata
  );
endinterface

// File: rtl/tty_ram_arbiter.sv
// Round-robin arbiter that puts NUM_CH clients onto one on-chip RAM port.
// Read data returns in order and is tagged with the channel id. hold freezes the whole pipeline.
module tty_ram_arbiter #(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             hold,
  tty_ram_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_CH);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_next;
  logic              accept;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W:0]     scan_sum;
  logic [ID_W-1:0]   scan_id;

  logic              cs_q;
  logic              write_q;
  logic [ID_W-1:0]   issue_id_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] writedata_q;
  tag_t              tag_pipe [READ_LATENCY];
  logic              rvalid_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] readdata_q;

  // Scan upward from ptr with wrap. The first requester wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    accept   = 1'b0;
    gnt_id   = '0;
    scan_sum = '0;
    scan_id  = '0;
    if (reset_reset_n && !hold) begin
      for (int i = 0; i < NUM_CH; i++) begin
        scan_sum = {1'b0, ptr} + (ID_W+1)'(i);
        if (scan_sum >= (ID_W+1)'(NUM_CH)) scan_sum = scan_sum - (ID_W+1)'(NUM_CH);
        scan_id = scan_sum[ID_W-1:0];
        if (!accept && bus.ch_req[scan_id]) begin
          accept = 1'b1;
          gnt_id = scan_id;
        end
      end
    end
  end

  assign ptr_next = (gnt_id == ID_W'(NUM_CH-1)) ? '0 : gnt_id + ID_W'(1);

  always_ff @(posedge clk_clk) begin
    // NOTE: all state uses non-blocking assignments, so every register samples pre-edge values.
    if (!reset_reset_n) begin
      ptr         <= '0;
      cs_q        <= 1'b0;
      write_q     <= 1'b0;
      issue_id_q  <= '0;
      address_q   <= '0;
      writedata_q <= '0;
      // NOTE: the tag pipeline is reset, unlike a RAM array, so reads in flight at reset never return.
      for (int i = 0; i < READ_LATENCY; i++) tag_pipe[i] <= '0;
      rvalid_q    <= 1'b0;
      rid_q       <= '0;
      readdata_q  <= '0;
    end else if (!hold) begin
      cs_q    <= accept;
      write_q <= accept & bus.ch_write[gnt_id];
      if (accept) begin
        ptr         <= ptr_next;
        issue_id_q  <= gnt_id;
        address_q   <= bus.ch_address[gnt_id*ADDR_W +: ADDR_W];
        writedata_q <= bus.ch_writedata[gnt_id*DATA_W +: DATA_W];
      end
      // The tag travels alongside the RAM's read latency. The last stage lines up with ram_readdata.
      tag_pipe[0] <= '{valid: cs_q & ~write_q, id: issue_id_q};
      for (int i = 1; i < READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      rvalid_q <= tag_pipe[READ_LATENCY-1].valid;
      rid_q    <= tag_pipe[READ_LATENCY-1].id;
      if (tag_pipe[READ_LATENCY-1].valid) readdata_q <= bus.ram_readdata;
    end
  end

  assign bus.ch_gnt         = accept ? (NUM_CH'(1) << gnt_id) : '0;
  assign bus.ch_rvalid      = (rvalid_q && !hold) ? (NUM_CH'(1) << rid_q) : '0;
  assign bus.ch_readdata    = readdata_q;
  assign bus.ram_address    = address_q;
  assign bus.ram_chipselect = cs_q;
  assign bus.ram_write      = write_q;
  assign bus.ram_writedata  = writedata_q;
  assign bus.ram_clken      = ~hold;
endmodule
